store_queue_ctrl: RTL and testbench
===================================

# store_queue_ctrl

Write-back store queue and memory-bus sequencer for the load/store unit. It accepts committed stores (SB/SH/SW/SWL/SWR) from the memory stage and derives byte-lane enables from address and store type. It merges same-word stores into the youngest pending entry, buffers up to DEPTH entries, and drains them in order to the data-memory port over a req/ack handshake. It also flags loads that hit a pending store word, so the pipeline can stall them.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store offered this cycle
- st_ready  out  1  queue can accept; `!full`
- st_addr  in  32  byte address of store
- st_sel  in  3  000 SB, 001 SH, 010 SW, 011 SWL, 100 SWR; 101–111 treated as SW
- st_data  in  32  store data, already lane-aligned by execute stage
- ld_check  in  1  load in memory stage requesting hazard check
- ld_addr  in  32  load byte address
- ld_hazard  out  1  combinational; pending store overlaps load word
- mem_req  out  1  registered; bus write request
- mem_addr  out  32  registered; word address, bits [1:0] = 0
- mem_wdata  out  32  registered; write data
- mem_be  out  4  registered; byte enables, bit i = byte lane i
- mem_ack  in  1  bus accepted current request this cycle
- sq_empty  out  1  no entries and no transfer in flight; used for SYNC/ERET drain

## Operation
- Lane select: `byte_sel = addr[1:0] ^ {2{`BigEndianCPU}}` (CPU_endianess.vh).
- Byte enables by store type:
  - SB: one-hot on `byte_sel`.
  - SH: 0011 if `byte_sel[1]`=0, else 1100; `addr[0]` ignored.
  - SW: 1111.
  - SWL: `byte_sel` 0..3 gives 0001/0011/0111/1111.
  - SWR: `byte_sel` 0..3 gives 1111/1110/1100/1000.
- Entry fields: valid, `word_addr[31:2]`, data[31:0], be[3:0].
- Circular FIFO with head/tail pointers and a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Accept condition: `st_valid && st_ready`.
  - Merge case: the youngest entry is valid, its `word_addr` equals `st_addr[31:2]`, and it is not the in-flight head. The store is merged: bytes with new be=1 overwrite data, be is ORed, count is unchanged.
  - Otherwise the store is written at tail; tail increments and count increments.
- Drain FSM:
  - IDLE: if count>0, load the head into the mem_* registers, set mem_req=1, go to BUSY.
  - BUSY: hold mem_addr/wdata/be stable while mem_ack=0. On mem_ack=1, pop the head.
    - If entries remain after the pop (excluding any entry accepted this same cycle), load the next head with mem_req staying 1 and stay in BUSY.
    - Otherwise set mem_req=0 and go to IDLE.
- Simultaneous accept and pop: count is unchanged (+1 −1). A merge combined with a pop leaves count −1.
- ld_hazard = `ld_check` && any valid entry (including the in-flight head) with `word_addr == ld_addr[31:2]`. A store accepted in the same cycle is not included.
- `sq_empty` = (count==0) && (state==IDLE).

## Timing
- Reset values: count=0, head=tail=0, all entry valid=0, state IDLE, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, st_ready=1 (after reset), sq_empty=1, ld_hazard=0.
- Reset mid-transfer: the queue is discarded; mem_req is 0 on the cycle after the rst edge. mem_ack is ignored while rst=1.
- Latency: a store accepted at edge E into an empty queue produces mem_req=1 from edge E+1.
- Throughput: back-to-back transfers complete one per cycle while mem_ack is held high.
- Full: st_ready=0 when count==DEPTH. st_ready does not rise in the same cycle as a pop; it rises on the following cycle.
- Merge does not require space, but it is gated by st_ready like any other accept.

## Test plan
- Reset → mem_req=0, mem_be=0, st_ready=1, sq_empty=1; hold rst with st_valid=1 → nothing enqueued.
- Little-endian SB to 0x1000_0003, data 0xAB00_0000, mem_ack tied to 1 → one transfer with mem_addr=0x1000_0000, mem_be=1000, mem_req high for exactly one cycle starting one cycle after accept.
- mem_ack=0, head in flight to 0x2000_0000, then SB 0x3000_0000 data 0x11 and SB 0x3000_0001 data 0x2200 → count=2; after acks, the second transfer has be=0011 and wdata[15:0]=0x2211.
- mem_ack=0, five SWs to distinct words → st_ready=0 after the fourth; the fifth is held. One ack → st_ready=1 on the next cycle, the fifth is accepted, and order is preserved.
- Pending SWR to 0x4000_0006 (be=1100); ld_check with ld_addr=0x4000_0004 → ld_hazard=1. ld_addr=0x4000_0008 → 0. After the store drains → 0.
- Reset asserted while mem_req=1 with three entries pending → mem_req=0 next cycle, sq_empty=1, no further requests issued.

Source files
------------

// File: rtl/store_queue_ctrl.sv
// Write-back store queue: store lane decode, merging into the youngest entry,
// in-order drain over a req/ack bus, and load-vs-pending-store hazard flag.
module store_queue_ctrl #(
  parameter int DEPTH      = 4,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_sel,
  input  logic [31:0] st_data,
  input  logic        ld_check,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        sq_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg, state_next;
  logic [AW-1:0]    head_reg, tail_reg;
  logic [CW-1:0]    count_reg;
  logic [DEPTH-1:0] valid_reg;
  logic [29:0]      waddr_mem [DEPTH];
  logic [31:0]      data_mem  [DEPTH];
  logic [3:0]       be_mem    [DEPTH];

  logic             mem_req_reg;
  logic [29:0]      mem_waddr_reg;
  logic [31:0]      mem_wdata_reg;
  logic [3:0]       mem_be_reg;

  logic [1:0]       byte_sel;
  logic [3:0]       st_be;
  logic             accept, merge, append, pop, load_en, fwd;
  logic [AW-1:0]    young_idx, load_idx;
  logic [31:0]      merged_data;
  logic [3:0]       merged_be;
  logic [DEPTH-1:0] ld_hit;
  logic             unused_ld_lsb;

  genvar gi;

  always_comb begin
    byte_sel = st_addr[1:0] ^ {2{BIG_ENDIAN}};
    st_be    = 4'b1111;
    case (st_sel)
      3'b000: st_be = 4'b0001 << byte_sel;
      3'b001: st_be = byte_sel[1] ? 4'b1100 : 4'b0011;
      3'b011: begin
        case (byte_sel)
          2'd0: st_be = 4'b0001;
          2'd1: st_be = 4'b0011;
          2'd2: st_be = 4'b0111;
          2'd3: st_be = 4'b1111;
        endcase
      end
      3'b100: begin
        case (byte_sel)
          2'd0: st_be = 4'b1111;
          2'd1: st_be = 4'b1110;
          2'd2: st_be = 4'b1100;
          2'd3: st_be = 4'b1000;
        endcase
      end
      default: st_be = 4'b1111;
    endcase
  end

  assign st_ready  = (count_reg != CW'(DEPTH));
  assign accept    = st_valid && st_ready;
  assign young_idx = tail_reg - AW'(1);
  assign pop       = (state_reg == BUSY) && mem_ack;

  // The head is on the bus while BUSY, so it must never absorb a merge.
  assign merge  = accept && valid_reg[young_idx]
                  && (waddr_mem[young_idx] == st_addr[31:2])
                  && !((state_reg == BUSY) && (young_idx == head_reg));
  assign append = accept && !merge;

  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign merged_data[8*gi +: 8] = st_be[gi] ? st_data[8*gi +: 8]
                                              : data_mem[young_idx][8*gi +: 8];
  end
  assign merged_be = be_mem[young_idx] | st_be;

  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    load_idx   = head_reg;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          load_en    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          if (count_reg > CW'(1)) begin
            load_en  = 1'b1;
            load_idx = head_reg + AW'(1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // An entry being loaded onto the bus in the same cycle it is merged must carry the merged bytes.
  assign fwd = merge && (load_idx == young_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      mem_req_reg   <= 1'b0;
      mem_waddr_reg <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      mem_req_reg <= (state_next == BUSY);
      if (load_en) begin
        mem_waddr_reg <= waddr_mem[load_idx];
        mem_wdata_reg <= fwd ? merged_data : data_mem[load_idx];
        mem_be_reg    <= fwd ? merged_be : be_mem[load_idx];
      end
      if (pop) head_reg <= head_reg + AW'(1);
      if (append) tail_reg <= tail_reg + AW'(1);
      case ({append, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (append && (tail_reg == AW'(i))) valid_reg[i] <= 1'b1;
        if (pop && (head_reg == AW'(i))) valid_reg[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (append && (tail_reg == AW'(i))) begin
        waddr_mem[i] <= st_addr[31:2];
        data_mem[i]  <= st_data;
        be_mem[i]    <= st_be;
      end else if (merge && (young_idx == AW'(i))) begin
        data_mem[i] <= merged_data;
        be_mem[i]   <= merged_be;
      end
    end
  end

  for (gi = 0; gi < DEPTH; gi++) begin : g_hit
    assign ld_hit[gi] = valid_reg[gi] && (waddr_mem[gi] == ld_addr[31:2]);
  end
  assign ld_hazard     = ld_check && (|ld_hit);
  assign unused_ld_lsb = ^ld_addr[1:0];

  assign mem_req   = mem_req_reg;
  assign mem_addr  = {mem_waddr_reg, 2'b00};
  assign mem_wdata = mem_wdata_reg;
  assign mem_be    = mem_be_reg;
  assign sq_empty  = (count_reg == '0) && (state_reg == IDLE);

endmodule

// File: tb/tb_store_queue_ctrl.sv
// Bench for store_queue_ctrl: queue-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_store_queue_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [2:0]  st_sel = '0;
  logic [31:0] st_data = '0;
  logic        ld_check = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        mem_ack = 1'b0;
  logic        st_ready, ld_hazard, mem_req, sq_empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_fail   = 0;

  store_queue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_sel(st_sel), .st_data(st_data),
    .ld_check(ld_check), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .sq_empty(sq_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t        q[$];
  bit          m_busy = 1'b0;
  bit          m_live = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_be = '0;
  logic [31:0] acked[$];

  function automatic logic [3:0] lanes(input logic [1:0] a, input logic [2:0] sel);
    int b;
    b = int'(a);
    case (sel)
      3'd0:    return 4'(1 << b);
      3'd1:    return (b >= 2) ? 4'hC : 4'h3;
      3'd3:    return 4'(15 >> (3 - b));
      3'd4:    return 4'(15 << b);
      default: return 4'hF;
    endcase
  endfunction

  function automatic bit exp_hazard();
    if (!ld_check) return 1'b0;
    foreach (q[k]) if (q[k].wa == ld_addr[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one update per rising edge from the inputs presented before it.
  always @(posedge clk) begin : model
    int n;
    bit acc, pp, mrg;
    logic [3:0] be;
    ent_t e;
    if (rst) begin
      q.delete();
      m_busy  = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_be    = '0;
      m_live  = 1'b1;
    end else if (m_live) begin
      n   = q.size();
      acc = st_valid && (n < DEPTH);
      pp  = m_busy && mem_ack;
      be  = lanes(st_addr[1:0], st_sel);
      if (acc) begin
        mrg = (n > 0) && (q[n-1].wa == st_addr[31:2]) && !(m_busy && n == 1);
        if (mrg) begin
          e = q[n-1];
          for (int l = 0; l < 4; l++) if (be[l]) e.d[8*l +: 8] = st_data[8*l +: 8];
          e.be = e.be | be;
          q[n-1] = e;
        end else begin
          e.wa = st_addr[31:2];
          e.d  = st_data;
          e.be = be;
          q.push_back(e);
        end
      end
      if (pp) void'(q.pop_front());
      if ((!m_busy && n > 0) || (pp && n > 1)) begin
        m_addr  = {q[0].wa, 2'b00};
        m_wdata = q[0].d;
        m_be    = q[0].be;
        m_busy  = 1'b1;
      end else if (pp) begin
        m_busy = 1'b0;
      end
    end
  end

  always @(posedge clk) if (!rst && mem_req && mem_ack) acked.push_back(mem_addr);

  always @(negedge clk) begin
    if (m_live) begin
      chk("mem_req", mem_req, m_busy);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_be", mem_be, m_be);
      chk("st_ready", st_ready, q.size() < DEPTH);
      chk("sq_empty", sq_empty, (q.size() == 0) && !m_busy);
      chk("ld_hazard", ld_hazard, exp_hazard());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_sel   = s;
    st_data  = d;
  endtask

  task automatic wait_empty(input int maxc, input string tag);
    int c;
    c = 0;
    while (!sq_empty && c < maxc) begin
      step();
      c++;
    end
    n_checks++;
    if (!sq_empty) begin
      n_fail++;
      $display("FAIL %s: sq_empty still 0 after %0d cycles", tag, maxc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [29:0] pool [4];
  logic [31:0] t4_addr [5];

  initial begin
    pool[0] = 30'h0000_0040; pool[1] = 30'h0000_0041;
    pool[2] = 30'h0400_0000; pool[3] = 30'h0400_0001;

    // Reset held with a store offered: nothing may be enqueued.
    put(32'h5000_0000, 3'd2, 32'h1234_5678);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    st_valid = 1'b0;
    ld_check = 1'b1;
    ld_addr = 32'h5000_0000;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_be", mem_be, 4'b0000);
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_sq_empty", sq_empty, 1'b1);
    chk("rst_ld_hazard", ld_hazard, 1'b0);
    ld_check = 1'b0;
    step();
    chk("rst_no_enqueue", sq_empty, 1'b1);

    // SB to lane 3 with ack tied high: single-cycle request one cycle after accept.
    mem_ack = 1'b1;
    put(32'h1000_0003, 3'd0, 32'hAB00_0000);
    step();
    st_valid = 1'b0;
    chk("sb_req_not_yet", mem_req, 1'b0);
    step();
    chk("sb_req", mem_req, 1'b1);
    chk("sb_addr", mem_addr, 32'h1000_0000);
    chk("sb_be", mem_be, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hAB00_0000);
    step();
    chk("sb_req_drop", mem_req, 1'b0);
    chk("sb_empty", sq_empty, 1'b1);

    // Merge of two SBs behind an in-flight head.
    mem_ack = 1'b0;
    put(32'h2000_0000, 3'd2, 32'hDEAD_BEEF);
    step();
    put(32'h3000_0000, 3'd0, 32'h0000_0011);
    step();
    put(32'h3000_0001, 3'd0, 32'h0000_2200);
    step();
    st_valid = 1'b0;
    chk("merge_count", q.size(), 2);
    chk("merge_head_addr", mem_addr, 32'h2000_0000);
    mem_ack = 1'b1;
    step();
    chk("merge_req", mem_req, 1'b1);
    chk("merge_addr", mem_addr, 32'h3000_0000);
    chk("merge_be", mem_be, 4'b0011);
    chk("merge_wdata", mem_wdata[15:0], 16'h2211);
    step();
    chk("merge_done", sq_empty, 1'b1);

    // Fill to DEPTH, hold a fifth store, release one slot, check ordering.
    mem_ack = 1'b0;
    acked.delete();
    for (int k = 0; k < 5; k++) t4_addr[k] = 32'h6000_0000 + 32'(k * 16);
    for (int k = 0; k < 4; k++) begin
      put(t4_addr[k], 3'd2, 32'(k));
      step();
    end
    chk("full_ready", st_ready, 1'b0);
    put(t4_addr[4], 3'd2, 32'd4);
    step();
    step();
    chk("full_held", q.size(), 4);
    chk("full_ready_hold", st_ready, 1'b0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("full_ready_rise", st_ready, 1'b1);
    step();
    st_valid = 1'b0;
    chk("full_refilled", st_ready, 1'b0);
    mem_ack = 1'b1;
    wait_empty(20, "full_drain");
    chk("full_ack_count", acked.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < acked.size()) chk($sformatf("full_order%0d", k), acked[k], t4_addr[k]);

    // Load hazard against a pending SWR.
    mem_ack = 1'b0;
    put(32'h4000_0006, 3'd4, 32'hCAFE_0000);
    step();
    st_valid = 1'b0;
    ld_check = 1'b1;
    ld_addr  = 32'h4000_0004;
    #1;
    chk("haz_hit", ld_hazard, 1'b1);
    ld_addr = 32'h4000_0008;
    #1;
    chk("haz_miss", ld_hazard, 1'b0);
    step();
    chk("haz_be", mem_be, 4'b1100);
    mem_ack = 1'b1;
    step();
    ld_addr = 32'h4000_0004;
    #1;
    chk("haz_drained", ld_hazard, 1'b0);
    ld_check = 1'b0;

    // Reset during a transfer with three entries pending.
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      put(32'h7000_0000 + 32'(k * 4), 3'd2, 32'(k + 100));
      step();
    end
    st_valid = 1'b0;
    chk("mrst_req_before", mem_req, 1'b1);
    chk("mrst_count", q.size(), 3);
    rst = 1'b1;
    mem_ack = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_req", mem_req, 1'b0);
    chk("mrst_empty", sq_empty, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mrst_quiet", mem_req, 1'b0);
    end

    // Randomized traffic on a small word pool to exercise merges and hazards.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 149) == 0);
      st_valid = ($urandom_range(0, 2) != 0);
      st_addr  = {pool[$urandom_range(0, 3)], 2'($urandom)};
      st_sel   = 3'($urandom);
      st_data  = $urandom;
      mem_ack  = ((c / 400) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      ld_check = $urandom_range(0, 1);
      ld_addr  = {pool[$urandom_range(0, 3)], 2'($urandom)};
      step();
    end
    rst = 1'b0;
    st_valid = 1'b0;
    ld_check = 1'b0;
    mem_ack = 1'b1;
    wait_empty(50, "final_drain");
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
